// File: rtl/arith_pkg.sv
// Shared types and constants for the calculator arithmetic unit.
// Optional build macro: ARITH_OVERFLOW_FLAG_EN (adds the ovf result flag).
package arith_pkg;

  localparam int ARITH_WIDTH = 16;

  // Operation encoding on the 2-bit op input; 2'b11 is reserved and behaves as ADD.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ADDSUB = 2'b01,
    MUL    = 2'b10,
    DONE   = 2'b11
  } state_t;

endpackage

// File: rtl/arith_unit_if.sv
// Request/result bundle between the calculator controller (master) and arith_unit (slave).
// Optional build macro: ARITH_OVERFLOW_FLAG_EN adds the ovf signal to both modports.
interface arith_unit_if
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) ();

  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [1:0]       op;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] out;
  logic             finish;

`ifdef ARITH_OVERFLOW_FLAG_EN
  logic             ovf;

  modport master (output in1, in2, op, start, input busy, out, finish, ovf);
  modport slave  (input in1, in2, op, start, output busy, out, finish, ovf);
`else
  modport master (output in1, in2, op, start, input busy, out, finish);
  modport slave  (input in1, in2, op, start, output busy, out, finish);
`endif

endinterface

// File: rtl/arith_unit_seq_multiplier.sv
// Iterative unsigned shift-add multiplier core: one partial-product add per cycle.
// o_done is high during the final iteration, with o_prod_nxt carrying the finished
// product, so the caller can capture the result on that same edge.
module seq_multiplier #(
  parameter int WIDTH  = 16,
  parameter int PROD_W = 2 * WIDTH,
  parameter int CYCLES = WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_run,
  input  logic [WIDTH-1:0]  i_mcand,
  input  logic [WIDTH-1:0]  i_mplier,
  output logic [PROD_W-1:0] o_prod_nxt,
  output logic              o_done
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [PROD_W-1:0] r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [PROD_W-1:0] r_prod;
  logic [CW-1:0]     r_cnt;
  logic [PROD_W-1:0] w_addend;

  // Partial product for the current multiplier bit.
  always_comb begin
    if (r_mplier[0]) begin
      w_addend = r_mcand;
    end else begin
      w_addend = '0;
    end
  end

  assign o_prod_nxt = r_prod + w_addend;
  assign o_done     = i_run && (r_cnt == CW'(1));

  // Load operands, then shift multiplicand left / multiplier right each run cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= PROD_W'(i_mcand);
      r_mplier <= i_mplier;
      r_prod   <= '0;
      r_cnt    <= CW'(CYCLES);
    end else if (i_run && (r_cnt != '0)) begin
      r_prod   <= o_prod_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end else begin
      r_mcand  <= r_mcand;
      r_mplier <= r_mplier;
      r_prod   <= r_prod;
      r_cnt    <= r_cnt;
    end
  end

endmodule

// File: rtl/arith_unit.sv
// Signed add/subtract/multiply engine behind a single start/finish handshake.
// Optional build macro: ARITH_OVERFLOW_FLAG_EN adds a registered ovf flag.
module arith_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  arith_unit_if.slave bus
);

  localparam int MUL_CYCLES = WIDTH;
`ifdef ARITH_OVERFLOW_FLAG_EN
  // Full-width product is needed to judge whether it fits in WIDTH bits.
  localparam int PROD_W = 2 * WIDTH;
`else
  // Only the low WIDTH bits of the product are ever delivered.
  localparam int PROD_W = WIDTH;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_sub;
  logic              r_neg;
  logic [WIDTH-1:0]  r_out;
  logic              r_finish;
  logic              r_busy;

  logic              w_accept;
  logic              w_mul_load;
  logic [WIDTH-1:0]  w_mag1;
  logic [WIDTH-1:0]  w_mag2;
  logic [WIDTH-1:0]  w_b_eff;
  logic [WIDTH-1:0]  w_sum;
  logic [PROD_W-1:0] w_prod_nxt;
  logic [PROD_W-1:0] w_prod_fix;
  logic              w_mul_done;
  logic [WIDTH-1:0]  w_result;
  logic              w_capture;

  // A request is only taken from IDLE; start in any other state is dropped.
  assign w_accept   = (r_state == IDLE) && bus.start;
  assign w_mul_load = w_accept && (bus.op == OP_MUL);

  // Magnitudes of the raw inputs feed the unsigned core on the start edge.
  assign w_mag1 = bus.in1[WIDTH-1] ? (~bus.in1 + WIDTH'(1)) : bus.in1;
  assign w_mag2 = bus.in2[WIDTH-1] ? (~bus.in2 + WIDTH'(1)) : bus.in2;

  // Subtract is A + ~B + 1; ADD and the reserved code use B unchanged.
  assign w_b_eff = r_sub ? ~r_b : r_b;
  assign w_sum   = r_a + w_b_eff + {{(WIDTH-1){1'b0}}, r_sub};

  // Restore the sign of the product when the operand signs differed.
  assign w_prod_fix = r_neg ? (~w_prod_nxt + PROD_W'(1)) : w_prod_nxt;

  seq_multiplier #(
    .WIDTH  (WIDTH),
    .PROD_W (PROD_W),
    .CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_mul_load),
    .i_run      (r_state == MUL),
    .i_mcand    (w_mag1),
    .i_mplier   (w_mag2),
    .o_prod_nxt (w_prod_nxt),
    .o_done     (w_mul_done)
  );

`ifdef ARITH_OVERFLOW_FLAG_EN
  logic r_ovf;
  logic w_ovf;
  logic w_as_ovf;
  logic w_mul_ovf;

  // Same-sign operands producing an opposite-sign sum overflowed.
  assign w_as_ovf  = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
  // Product fits only if the upper half plus bit WIDTH-1 is all-zeros or all-ones.
  assign w_mul_ovf = !((&w_prod_fix[PROD_W-1:WIDTH-1]) || !(|w_prod_fix[PROD_W-1:WIDTH-1]));
  assign bus.ovf   = r_ovf;
`endif

  assign bus.out    = r_out;
  assign bus.finish = r_finish;
  assign bus.busy   = r_busy;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and result selection for the capture edge into DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_result    = '0;
    w_capture   = 1'b0;
`ifdef ARITH_OVERFLOW_FLAG_EN
    w_ovf       = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            w_state_nxt = MUL;
          end else begin
            w_state_nxt = ADDSUB;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ADDSUB: begin
        w_result    = w_sum;
        w_capture   = 1'b1;
        w_state_nxt = DONE;
`ifdef ARITH_OVERFLOW_FLAG_EN
        w_ovf       = w_as_ovf;
`endif
      end
      MUL: begin
        if (w_mul_done) begin
          w_result    = w_prod_fix[WIDTH-1:0];
          w_capture   = 1'b1;
          w_state_nxt = DONE;
`ifdef ARITH_OVERFLOW_FLAG_EN
          w_ovf       = w_mul_ovf;
`endif
        end else begin
          w_state_nxt = MUL;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Latch operands and op on an accepted start; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sub <= 1'b0;
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_a   <= bus.in1;
      r_b   <= bus.in2;
      r_sub <= (bus.op == OP_SUB);
      r_neg <= bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1];
    end else begin
      r_a   <= r_a;
      r_b   <= r_b;
      r_sub <= r_sub;
      r_neg <= r_neg;
    end
  end

  // Registered handshake outputs: out/finish set entering DONE, busy spans the op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out    <= '0;
      r_finish <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_finish <= w_capture;
      if (w_capture) begin
        r_out <= w_result;
      end else begin
        r_out <= r_out;
      end
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (r_state == DONE) begin
        r_busy <= 1'b0;
      end else begin
        r_busy <= r_busy;
      end
    end
  end

`ifdef ARITH_OVERFLOW_FLAG_EN
  // Overflow flag follows out: updated only when a result is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_capture) begin
      r_ovf <= w_ovf;
    end else begin
      r_ovf <= r_ovf;
    end
  end
`endif

endmodule

// File: tb/tb_arith_unit.sv
// Directed-vector bench for arith_unit: latency, results, handshake and reset abort.
module tb_arith_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  arith_unit_if #(.WIDTH(16)) u_if ();

  arith_unit #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op from a negedge; returns at the negedge one cycle after finish.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_out, input int exp_lat,
                       input logic exp_ovf, input int inject_at, input bit poke_fin);
    int lat;
    lat = 0;
    u_if.in1   = a;
    u_if.in2   = b;
    u_if.op    = op;
    u_if.start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        u_if.start = 1'b0;
        u_if.in1   = 16'h5555;
        u_if.in2   = 16'hAAAA;
        u_if.op    = 2'b01;
        chk({tag, "_busy"}, 32'(u_if.busy), 32'd1);
      end
      if (k == inject_at) begin
        u_if.start = 1'b1;
        u_if.in1   = 16'd9;
        u_if.in2   = 16'd9;
        u_if.op    = 2'b10;
      end else if (k == inject_at + 1) begin
        u_if.start = 1'b0;
      end
      if (u_if.finish) begin
        lat = k;
        break;
      end
    end
    u_if.start = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_out"}, 32'(u_if.out), 32'(exp_out));
`ifdef ARITH_OVERFLOW_FLAG_EN
    chk({tag, "_ovf"}, 32'(u_if.ovf), 32'(exp_ovf));
`endif
    if (poke_fin) begin
      u_if.in1   = 16'd100;
      u_if.in2   = 16'd100;
      u_if.op    = 2'b00;
      u_if.start = 1'b1;
    end
    @(negedge clk);
    u_if.start = 1'b0;
    chk({tag, "_fin1cyc"}, 32'(u_if.finish), 32'd0);
    chk({tag, "_idle"}, 32'(u_if.busy), 32'd0);
    chk({tag, "_hold"}, 32'(u_if.out), 32'(exp_out));
    if (poke_fin) begin
      @(negedge clk);
      chk({tag, "_poke_busy"}, 32'(u_if.busy), 32'd0);
      @(negedge clk);
      chk({tag, "_poke_fin"}, 32'(u_if.finish), 32'd0);
      chk({tag, "_poke_out"}, 32'(u_if.out), 32'(exp_out));
    end
  endtask

  initial begin
    int fin_seen;
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    u_if.in1   = 16'd0;
    u_if.in2   = 16'd0;
    u_if.op    = 2'b00;
    u_if.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out", 32'(u_if.out), 32'd0);
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    chk("rst_fin", 32'(u_if.finish), 32'd0);
`ifdef ARITH_OVERFLOW_FLAG_EN
    chk("rst_ovf", 32'(u_if.ovf), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Give out a nonzero value, then abort a MUL with reset.
    do_op("add7_8", 2'b00, 16'd7, 16'd8, 16'd15, 2, 1'b0, 0, 1'b0);
    u_if.in1   = 16'd100;
    u_if.in2   = 16'd3;
    u_if.op    = 2'b10;
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out", 32'(u_if.out), 32'd0);
    chk("abort_busy", 32'(u_if.busy), 32'd0);
    rst = 1'b0;
    fin_seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (u_if.finish) fin_seen++;
    end
    chk("abort_nofin", 32'(fin_seen), 32'd0);
    chk("abort_still_idle", 32'(u_if.busy), 32'd0);
    do_op("add2_2", 2'b00, 16'd2, 16'd2, 16'd4, 2, 1'b0, 0, 1'b0);

    // Add/subtract, including wrap and the reserved op code.
    do_op("add1234", 2'b00, 16'd1234, 16'd5678, 16'd6912, 2, 1'b0, 0, 1'b0);
    do_op("sub5_9", 2'b01, 16'd5, 16'd9, 16'hFFFC, 2, 1'b0, 0, 1'b0);
    do_op("add_wrap", 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 2, 1'b1, 0, 1'b0);
    do_op("sub_wrap", 2'b01, 16'h8000, 16'h0001, 16'h7FFF, 2, 1'b1, 0, 1'b0);
    do_op("rsvd_add", 2'b11, 16'd3, 16'd4, 16'd7, 2, 1'b0, 0, 1'b0);

    // Digit accumulation, issued back-to-back (start in cycle after finish).
    do_op("mul123x10", 2'b10, 16'd123, 16'd10, 16'd1230, 17, 1'b0, 0, 1'b0);
    do_op("acc_digit", 2'b00, 16'd1230, 16'd4, 16'd1234, 2, 1'b0, 0, 1'b0);

    // Signed multiply and edge values.
    do_op("mul_m7x6", 2'b10, 16'hFFF9, 16'd6, 16'hFFD6, 17, 1'b0, 0, 1'b0);
    do_op("mul_m7xm6", 2'b10, 16'hFFF9, 16'hFFFA, 16'd42, 17, 1'b0, 0, 1'b0);
    do_op("mul_0xmin", 2'b10, 16'd0, 16'h8000, 16'd0, 17, 1'b0, 0, 1'b0);
    do_op("mul_minxm1", 2'b10, 16'h8000, 16'hFFFF, 16'h8000, 17, 1'b1, 0, 1'b0);
    do_op("mul_300sq", 2'b10, 16'd300, 16'd300, 16'h5F90, 17, 1'b1, 0, 1'b0);

    // Start during MUL is ignored; start on the finish cycle is ignored.
    do_op("mul_inject", 2'b10, 16'd25, 16'hFFFC, 16'hFF9C, 17, 1'b0, 5, 1'b0);
    do_op("add_poke", 2'b00, 16'd1, 16'd2, 16'd3, 2, 1'b0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
